// File: rtl/branch_resolve_bht_pkg.sv
// Shared opcode/func3 codes and constants for the EX branch resolution unit
// and its branch history table.
package branch_resolve_bht_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] FNC_BEQ  = 3'b000;
   localparam logic [2:0] FNC_BNE  = 3'b001;
   localparam logic [2:0] FNC_BLT  = 3'b100;
   localparam logic [2:0] FNC_BGE  = 3'b101;
   localparam logic [2:0] FNC_BLTU = 3'b110;
   localparam logic [2:0] FNC_BGEU = 3'b111;

   localparam int PC_INC   = 4;
   localparam int BHT_INIT = 1;

   typedef enum logic [1:0] {
      CF_NONE,
      CF_BRANCH,
      CF_JAL,
      CF_JALR
   } cf_kind_e;

   function automatic logic is_unsigned_branch(input logic [6:0] opc, input logic [2:0] f3);
      return (opc == OPC_BRANCH) && ((f3 == FNC_BLTU) || (f3 == FNC_BGEU));
   endfunction

endpackage

// File: rtl/branch_resolve_bht_bht_counter_array.sv
// Flop array of saturating counters: one combinational read port and one
// saturating increment/decrement write port; async reset to weakly not-taken.
module bht_counter_array
   import branch_resolve_bht_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int CNT_W = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
   output logic [CNT_W-1:0]         rd_cnt_o,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
   input  logic                     wr_inc_i
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MIN = '0;

   logic [CNT_W-1:0] cnt_q [DEPTH];
   logic [CNT_W-1:0] wr_cur;
   logic [CNT_W-1:0] cnt_d;

   function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cur,
                                                 input logic             inc);
      logic [CNT_W-1:0] nxt;
      nxt = cur;
      if (inc) begin
         if (cur != CNT_MAX) nxt = cur + 1'b1;
      end else begin
         if (cur != CNT_MIN) nxt = cur - 1'b1;
      end
      return nxt;
   endfunction

   // Reads see the stored value only; a same-cycle write is not forwarded.
   assign rd_cnt_o = cnt_q[rd_idx_i];
   assign wr_cur   = cnt_q[wr_idx_i];
   assign cnt_d    = sat_step(wr_cur, wr_inc_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            cnt_q[i] <= CNT_W'(BHT_INIT);
         end
      end else if (wr_en_i) begin
         cnt_q[wr_idx_i] <= cnt_d;
      end
   end

endmodule

// File: rtl/branch_resolve_bht.sv
// EX-stage branch/jump resolution with BHT prediction for IF, registered
// redirect on mispredict, and branch/mispredict performance counters.
module branch_resolve_bht
   import branch_resolve_bht_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 64,
   parameter int CNT_W     = 2,
   parameter int PERF_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   if_pc,
   output logic              if_pred_taken,
   input  logic              ex_valid,
   input  logic              ex_stall,
   input  logic [XLEN-1:0]   ex_pc,
   input  logic              ex_pred_taken,
   input  logic [6:0]        opcode,
   input  logic [2:0]        func3,
   input  logic              branch_eq,
   input  logic              branch_lt,
   input  logic [XLEN-1:0]   alu_target,
   output logic              branch_unsign,
   output logic              redirect,
   output logic [XLEN-1:0]   redirect_pc,
   output logic [PERF_W-1:0] perf_branches,
   output logic [PERF_W-1:0] perf_mispredicts
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [IDX_W-1:0]  if_idx;
   logic [IDX_W-1:0]  ex_idx;
   logic [CNT_W-1:0]  if_cnt;
   cf_kind_e          kind;
   logic              cond;
   logic              resolve;
   logic              br_resolve;
   logic              mispredict;
   logic [XLEN-1:0]   correct_pc;

   logic              redirect_q,     redirect_d;
   logic [XLEN-1:0]   redirect_pc_q,  redirect_pc_d;
   logic [PERF_W-1:0] perf_br_q,      perf_br_d;
   logic [PERF_W-1:0] perf_mp_q,      perf_mp_d;

   logic              unused_bits;

   assign if_idx = if_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];

   bht_counter_array #(
      .DEPTH (BHT_DEPTH),
      .CNT_W (CNT_W)
   ) u_bht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx_i (if_idx),
      .rd_cnt_o (if_cnt),
      .wr_en_i  (br_resolve),
      .wr_idx_i (ex_idx),
      .wr_inc_i (cond)
   );

   assign if_pred_taken = if_cnt[CNT_W-1];
   assign branch_unsign = is_unsigned_branch(opcode, func3);

   // func3 010/011 under the branch opcode is not a branch at all.
   always_comb begin
      kind = CF_NONE;
      cond = 1'b0;
      unique case (opcode)
         OPC_BRANCH: begin
            kind = CF_BRANCH;
            unique case (func3)
               FNC_BEQ:            cond = branch_eq;
               FNC_BNE:            cond = ~branch_eq;
               FNC_BLT, FNC_BLTU:  cond = branch_lt;
               FNC_BGE, FNC_BGEU:  cond = ~branch_lt;
               default:            kind = CF_NONE;
            endcase
         end
         OPC_JAL:  kind = CF_JAL;
         OPC_JALR: kind = CF_JALR;
         default:  kind = CF_NONE;
      endcase
   end

   // A live redirect squashes whatever wrong-path instruction sits in EX.
   assign resolve    = ex_valid & ~ex_stall & ~redirect_q;
   assign br_resolve = resolve & (kind == CF_BRANCH);
   assign mispredict = resolve & (((kind == CF_BRANCH) & (cond != ex_pred_taken)) |
                                  (kind == CF_JAL) | (kind == CF_JALR));

   always_comb begin
      correct_pc = ex_pc + XLEN'(PC_INC);
      unique case (kind)
         CF_JALR:   correct_pc = {alu_target[XLEN-1:1], 1'b0};
         CF_JAL:    correct_pc = alu_target;
         CF_BRANCH: if (cond) correct_pc = alu_target;
         default:   correct_pc = ex_pc + XLEN'(PC_INC);
      endcase
   end

   always_comb begin
      redirect_d    = mispredict;
      redirect_pc_d = mispredict ? correct_pc : redirect_pc_q;
      perf_br_d     = perf_br_q + PERF_W'(br_resolve);
      perf_mp_d     = perf_mp_q + PERF_W'(mispredict);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         perf_br_q     <= '0;
         perf_mp_q     <= '0;
      end else begin
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         perf_br_q     <= perf_br_d;
         perf_mp_q     <= perf_mp_d;
      end
   end

   assign redirect         = redirect_q;
   assign redirect_pc      = redirect_pc_q;
   assign perf_branches    = perf_br_q;
   assign perf_mispredicts = perf_mp_q;

   assign unused_bits = ^{if_pc, ex_pc[1:0], if_cnt[CNT_W-2:0]};

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed-sequence bench for branch_resolve_bht with a behavioural BHT/redirect
// model feeding an expected-result queue; a PERF_W=4 copy shares the stimulus.
module tb_branch_resolve_bht;

   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] ALU  = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] if_pc = 32'h100;
   logic        ex_valid = 1'b0, ex_stall = 1'b0, ex_pred_taken = 1'b0;
   logic [31:0] ex_pc = '0, alu_target = '0;
   logic [6:0]  opcode = '0;
   logic [2:0]  func3 = '0;
   logic        branch_eq = 1'b0, branch_lt = 1'b0;

   logic        if_pred_taken, branch_unsign, redirect;
   logic [31:0] redirect_pc, perf_branches, perf_mispredicts;
   logic        if_pred_taken4, branch_unsign4, redirect4;
   logic [31:0] redirect_pc4;
   logic [3:0]  perf_branches4, perf_mispredicts4;

   always #5 clk = ~clk;

   branch_resolve_bht dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
      .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc),
      .ex_pred_taken(ex_pred_taken), .opcode(opcode), .func3(func3),
      .branch_eq(branch_eq), .branch_lt(branch_lt), .alu_target(alu_target),
      .branch_unsign(branch_unsign), .redirect(redirect), .redirect_pc(redirect_pc),
      .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
   );

   branch_resolve_bht #(.PERF_W(4)) dut4 (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken4),
      .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc),
      .ex_pred_taken(ex_pred_taken), .opcode(opcode), .func3(func3),
      .branch_eq(branch_eq), .branch_lt(branch_lt), .alu_target(alu_target),
      .branch_unsign(branch_unsign4), .redirect(redirect4), .redirect_pc(redirect_pc4),
      .perf_branches(perf_branches4), .perf_mispredicts(perf_mispredicts4)
   );

   typedef struct {
      string       tag;
      logic        redir;
      logic [31:0] rpc;
      int          br;
      int          mp;
   } exp_t;

   exp_t        sbq[$];
   int          n_total = 0;
   int          n_pass  = 0;
   int          n_fail  = 0;

   int          bht[64];
   logic        m_redir;
   logic [31:0] m_rpc;
   int          m_br, m_mp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) bht[i] = 1;
      m_redir = 1'b0;
      m_rpc   = '0;
      m_br    = 0;
      m_mp    = 0;
   endtask

   function automatic logic model_pred(input logic [31:0] pc);
      return bht[(pc >> 2) & 32'h3f] >= 2;
   endfunction

   task automatic step(input string tag, input bit v, input bit st, input logic [31:0] pc,
                       input bit pred, input logic [6:0] opc, input logic [2:0] f3,
                       input bit eq, input bit lt, input logic [31:0] tgt);
      exp_t        e, got;
      bit          res, isb, isj, cond, mis;
      logic [31:0] cpc;
      int          ix;
      @(negedge clk);
      ex_valid = v; ex_stall = st; ex_pc = pc; ex_pred_taken = pred;
      opcode = opc; func3 = f3; branch_eq = eq; branch_lt = lt; alu_target = tgt;
      #1;
      chk({tag, ".pred"}, 32'(if_pred_taken), 32'(model_pred(if_pc)));
      chk({tag, ".unsign"}, 32'(branch_unsign), 32'((opc == BR) && (f3 == 3'd6 || f3 == 3'd7)));
      res  = v && !st && !m_redir;
      isb  = 1'b0;
      cond = 1'b0;
      if (opc == BR) begin
         case (f3)
            3'd0:       begin isb = 1'b1; cond = eq;  end
            3'd1:       begin isb = 1'b1; cond = !eq; end
            3'd4, 3'd6: begin isb = 1'b1; cond = lt;  end
            3'd5, 3'd7: begin isb = 1'b1; cond = !lt; end
            default:    isb = 1'b0;
         endcase
      end
      isj = (opc == JAL) || (opc == JALR);
      mis = res && (isj || (isb && (cond != pred)));
      if (opc == JALR)                 cpc = tgt & ~32'h1;
      else if (opc == JAL || cond)     cpc = tgt;
      else                             cpc = pc + 32'd4;
      if (res && isb) begin
         m_br++;
         ix = int'((pc >> 2) & 32'h3f);
         if (cond && bht[ix] < 3)       bht[ix]++;
         else if (!cond && bht[ix] > 0) bht[ix]--;
      end
      if (mis) begin
         m_mp++;
         m_rpc = cpc;
      end
      m_redir = mis;
      e.tag = tag; e.redir = m_redir; e.rpc = m_rpc; e.br = m_br; e.mp = m_mp;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      got = sbq.pop_front();
      chk({got.tag, ".redirect"}, 32'(redirect), 32'(got.redir));
      chk({got.tag, ".rpc"}, redirect_pc, got.rpc);
      chk({got.tag, ".nbr"}, perf_branches, 32'(got.br));
      chk({got.tag, ".nmp"}, perf_mispredicts, 32'(got.mp));
      chk({got.tag, ".nbr4"}, 32'(perf_branches4), 32'(got.br % 16));
      chk({got.tag, ".nmp4"}, 32'(perf_mispredicts4), 32'(got.mp % 16));
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 1'b0, 32'h0, 1'b0, ALU, 3'd0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst.redirect", 32'(redirect), 32'h0);
      chk("rst.rpc", redirect_pc, 32'h0);
      chk("rst.nbr", perf_branches, 32'h0);
      chk("rst.nmp", perf_mispredicts, 32'h0);
      chk("rst.pred", 32'(if_pred_taken), 32'h0);

      // first taken BEQ mispredicts, trains entry 0 to 2
      if_pc = 32'h100;
      step("beq_tk", 1, 0, 32'h100, 0, BR, 3'd0, 1, 0, 32'h140);
      idle("after_beq");
      for (int i = 0; i < 4; i++)
         step("beq_sat", 1, 0, 32'h100, 1, BR, 3'd0, 1, 0, 32'h140);
      step("beq_nt1", 1, 0, 32'h100, 1, BR, 3'd0, 0, 0, 32'h140);
      // wrong-path BNE during the redirect cycle is squashed
      step("bne_kill", 1, 0, 32'h100, 0, BR, 3'd1, 0, 0, 32'h180);
      step("beq_nt2", 1, 0, 32'h100, 1, BR, 3'd0, 0, 0, 32'h140);
      idle("after_nt2");

      step("jalr", 1, 0, 32'h100, 0, JALR, 3'd0, 0, 0, 32'h203);
      idle("after_jalr");

      // BLTU held by stall, then resolves once the stall drops
      if_pc = 32'h180;
      step("bltu_stall", 1, 1, 32'h180, 0, BR, 3'd6, 0, 1, 32'h1c0);
      step("bltu_go", 1, 0, 32'h180, 0, BR, 3'd6, 0, 1, 32'h1c0);
      idle("after_bltu");
      step("bgeu_nt", 1, 0, 32'h180, 1, BR, 3'd7, 0, 1, 32'h1c0);
      idle("after_bgeu");
      step("blt_nt", 1, 0, 32'h180, 0, BR, 3'd4, 0, 0, 32'h1c0);
      step("bge_tk", 1, 0, 32'h180, 0, BR, 3'd5, 0, 0, 32'h1f0);
      idle("after_bge");
      step("f3_undef", 1, 0, 32'h180, 0, BR, 3'd2, 1, 1, 32'h1c0);
      step("alu_op", 1, 0, 32'h180, 0, ALU, 3'd0, 1, 1, 32'h1c0);
      step("invalid", 0, 0, 32'h180, 0, BR, 3'd0, 1, 0, 32'h1c0);

      // enough redirects to wrap the 4-bit counter copy
      if_pc = 32'h300;
      for (int i = 0; i < 16; i++) begin
         step("jal_loop", 1, 0, 32'h300, 0, JAL, 3'd0, 0, 0, 32'h400 + 32'(i * 4));
         idle("jal_gap");
      end
      chk("mp4_wrapped", 32'(perf_mispredicts4), 32'(m_mp % 16));

      // retrain entry 0, then reset asynchronously while redirect is high
      if_pc = 32'h100;
      step("re_tk1", 1, 0, 32'h100, 0, BR, 3'd0, 1, 0, 32'h140);
      idle("re_gap");
      step("re_tk2", 1, 0, 32'h100, 1, BR, 3'd0, 1, 0, 32'h140);
      step("jal_pre_rst", 1, 0, 32'h500, 0, JAL, 3'd0, 0, 0, 32'h600);
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      chk("arst.redirect", 32'(redirect), 32'h0);
      chk("arst.rpc", redirect_pc, 32'h0);
      chk("arst.nbr", perf_branches, 32'h0);
      chk("arst.nmp", perf_mispredicts, 32'h0);
      chk("arst.pred", 32'(if_pred_taken), 32'h0);
      #1;
      rst = 1'b0;
      step("post_rst_beq", 1, 0, 32'h100, 0, BR, 3'd0, 1, 0, 32'h140);
      idle("post_rst_idle");
      idle("post_rst_final");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
